// File: rtl/fp_argmax_stream.sv
// fp_argmax_stream
// ----------------
// Streaming max/min reduction over a vector of sign-magnitude floats
// (binary16 by default). Elements arrive on a valid/ready stream that is
// terminated by in_last. The unit returns the extreme element, its index
// and a sticky NaN flag on a valid/ready output stream. It inserts one
// bubble cycle per vector.
//
// Ports:
//   clk       clock
//   rstn      synchronous reset, active-low
//   mode      0 = max, 1 = min; latched with the first beat of a vector
//   in_valid  input beat valid
//   in_ready  unit can accept a beat (combinational: IDLE or ACCUM)
//   in_data   float element (W = 1+EXP_W+MAN_W bits)
//   in_last   final element of the vector
//   out_valid result valid (HOLD state)
//   out_ready downstream accepts the result
//   out_data  winning element, original bit pattern (canonical qNaN if all NaN)
//   out_idx   index of the winner, first beat is index 0 (wraps mod 2^IDX_W)
//   out_nan   at least one NaN was seen in the vector
module fp_argmax_stream #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int IDX_W = 8,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_nan
);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] ZERO_KEY = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t            state_reg, state_next;
    logic              mode_reg;
    logic [W-1:0]      cand_reg;
    logic [IDX_W-1:0]  cand_idx_reg;
    logic              have_reg;
    logic              nan_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [W-1:0]      data_reg;
    logic [IDX_W-1:0]  res_idx_reg;
    logic              res_nan_reg;

    logic              accept;
    logic              first_beat;
    logic              mode_eff;
    logic              have_eff;
    logic              nan_eff;
    logic              in_is_nan;
    logic [W-1:0]      in_key;
    logic [W-1:0]      cand_key;
    logic              take;
    logic [W-1:0]      cand_next;
    logic [IDX_W-1:0]  cand_idx_next;
    logic              have_next;
    logic              nan_next;

    // Maps a non-NaN float onto an unsigned key whose order matches the real
    // ordering. Both zeros share one key so +0 and -0 tie.
    function automatic logic [W-1:0] order_key(input logic [W-1:0] x);
        if (x[W-2:0] == '0)
            return ZERO_KEY;
        else if (!x[W-1])
            return {1'b1, x[W-2:0]};
        else
            return ~x;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = in_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last)
                    state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Comparator ----------------
    assign accept     = in_valid & in_ready;
    assign first_beat = (state_reg == IDLE);

    // On the first beat the live mode input applies and any leftover
    // candidate/NaN state from the previous vector is ignored.
    assign mode_eff  = first_beat ? mode : mode_reg;
    assign have_eff  = first_beat ? 1'b0 : have_reg;
    assign nan_eff   = first_beat ? 1'b0 : nan_reg;
    assign in_is_nan = (&in_data[W-2:MAN_W]) & (|in_data[MAN_W-1:0]);
    assign in_key    = order_key(in_data);
    assign cand_key  = order_key(cand_reg);

    // Strict comparison only: ties keep the earlier element.
    assign take = !in_is_nan &&
                  (!have_eff || (mode_eff ? (in_key < cand_key) : (in_key > cand_key)));

    assign cand_next     = take ? in_data : cand_reg;
    assign cand_idx_next = take ? idx_reg : cand_idx_reg;
    assign have_next     = have_eff | take;
    assign nan_next      = nan_eff | in_is_nan;

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode_reg     <= 1'b0;
            cand_reg     <= '0;
            cand_idx_reg <= '0;
            have_reg     <= 1'b0;
            nan_reg      <= 1'b0;
            idx_reg      <= '0;
            data_reg     <= '0;
            res_idx_reg  <= '0;
            res_nan_reg  <= 1'b0;
        end else if (accept) begin
            mode_reg     <= mode_eff;
            cand_reg     <= cand_next;
            cand_idx_reg <= cand_idx_next;
            have_reg     <= have_next;
            nan_reg      <= nan_next;
            if (in_last) begin
                idx_reg     <= '0;
                data_reg    <= have_next ? cand_next : QNAN;
                res_idx_reg <= have_next ? cand_idx_next : '0;
                res_nan_reg <= nan_next;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign out_data = data_reg;
    assign out_idx  = res_idx_reg;
    assign out_nan  = res_nan_reg;

endmodule

// File: tb/tb_fp_argmax_stream.sv
// Testbench for fp_argmax_stream. Two instances share the input stream:
// dut uses the default IDX_W=8, dut2 uses IDX_W=2 to exercise index wrap.
module tb_fp_argmax_stream;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_idx;
    logic        out_nan;

    logic        in_ready2;
    logic        out_valid2;
    logic [15:0] out_data2;
    logic [1:0]  out_idx2;
    logic        out_nan2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] vec_q[$];

    always #5 clk = ~clk;

    fp_argmax_stream dut (
        .clk(clk), .rstn(rstn), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_nan(out_nan)
    );

    fp_argmax_stream #(.IDX_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .mode(mode), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_idx(out_idx2), .out_nan(out_nan2)
    );

    typedef struct {
        int              n;
        logic            m;
        logic [7:0][15:0] d;
        logic [15:0]     exp_d;
        int              exp_i;
        logic            exp_n;
        int              hold;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: signed real-valued ordering via magnitude.
    function automatic int sval(input logic [15:0] x);
        int mag;
        mag = int'(x[14:0]);
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1f) && (x[9:0] != 10'h0);
    endfunction

    task automatic model(input logic m, output logic [15:0] d, output int i, output logic n);
        logic found;
        int   best;
        found = 1'b0; best = 0; n = 1'b0; d = 16'h7E00; i = 0;
        for (int k = 0; k < vec_q.size(); k++) begin
            if (is_nan(vec_q[k])) begin
                n = 1'b1;
            end else if (!found || (m ? (sval(vec_q[k]) < best) : (sval(vec_q[k]) > best))) begin
                found = 1'b1;
                best  = sval(vec_q[k]);
                d     = vec_q[k];
                i     = k;
            end
        end
    endtask

    // Drive one beat at a negedge and wait (bounded) for it to be accepted.
    task automatic beat(input logic [15:0] d, input logic l, input logic m);
        int cnt;
        in_valid = 1'b1; in_data = d; in_last = l; mode = m;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_vector(input logic m, input logic [15:0] ed, input int ei,
                              input logic en, input int hold);
        int n;
        n = vec_q.size();
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("out_valid_before_last", out_valid, 1'b0);
            beat(vec_q[i], i == n - 1, (i == 0) ? m : 1'($urandom));
        end
        chk("out_valid_latency", out_valid, 1'b1);
        chk("in_ready_in_hold", in_ready, 1'b0);
        chk("out_data", out_data, ed);
        chk("out_idx", out_idx, 32'(ei % 256));
        chk("out_nan", out_nan, en);
        chk("out_data_w2", out_data2, ed);
        chk("out_idx_w2", out_idx2, 32'(ei % 4));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_data", out_data, ed);
            chk("bp_out_idx", out_idx, 32'(ei % 256));
            chk("bp_out_nan", out_nan, en);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 1'b0);
        chk("release_in_ready", in_ready, 1'b1);
    endtask

    function automatic logic [15:0] rand_elem();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7C00;
            3: return 16'hFC00;
            4: return {1'($urandom), 5'h1f, 10'($urandom_range(1, 1023))};
            5: return ($urandom_range(0, 1) == 0) ? 16'h3C00 : 16'hBC00;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] ed;
        int          ei;
        logic        en;
        int          len;
        logic        m;

        rstn = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_out_idx", out_idx, 8'h0);
        chk("rst_out_nan", out_nan, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // ---- directed table ----
        tbl[0] = '{n:4, m:1'b0, d:'0, exp_d:16'h4000, exp_i:1, exp_n:1'b0, hold:5};
        tbl[0].d[0] = 16'h3C00; tbl[0].d[1] = 16'h4000; tbl[0].d[2] = 16'hC000; tbl[0].d[3] = 16'hBC00;
        tbl[1] = tbl[0]; tbl[1].m = 1'b1; tbl[1].exp_d = 16'hC000; tbl[1].exp_i = 2; tbl[1].hold = 0;
        tbl[2] = '{n:2, m:1'b0, d:'0, exp_d:16'h8000, exp_i:0, exp_n:1'b0, hold:0};
        tbl[2].d[0] = 16'h8000; tbl[2].d[1] = 16'h0000;
        tbl[3] = '{n:3, m:1'b0, d:'0, exp_d:16'h7C00, exp_i:2, exp_n:1'b1, hold:1};
        tbl[3].d[0] = 16'h7E00; tbl[3].d[1] = 16'hFC00; tbl[3].d[2] = 16'h7C00;
        tbl[4] = '{n:1, m:1'b0, d:'0, exp_d:16'h7E00, exp_i:0, exp_n:1'b1, hold:0};
        tbl[4].d[0] = 16'h7E01;
        tbl[5] = '{n:6, m:1'b0, d:'0, exp_d:16'h4400, exp_i:5, exp_n:1'b0, hold:0};
        tbl[5].d[0] = 16'h3C00; tbl[5].d[1] = 16'h3C00; tbl[5].d[2] = 16'h3800;
        tbl[5].d[3] = 16'h4000; tbl[5].d[4] = 16'h3000; tbl[5].d[5] = 16'h4400;
        tbl[6] = '{n:3, m:1'b1, d:'0, exp_d:16'h0000, exp_i:1, exp_n:1'b0, hold:2};
        tbl[6].d[0] = 16'h3C00; tbl[6].d[1] = 16'h0000; tbl[6].d[2] = 16'h8000;

        for (int t = 0; t < 7; t++) begin
            vec_q.delete();
            for (int k = 0; k < tbl[t].n; k++) vec_q.push_back(tbl[t].d[k]);
            run_vector(tbl[t].m, tbl[t].exp_d, tbl[t].exp_i, tbl[t].exp_n, tbl[t].hold);
            $display("vector %0d: mode=%0d len=%0d -> data=%04h idx=%0d nan=%0d",
                     t, tbl[t].m, tbl[t].n, out_data, out_idx, out_nan);
        end

        // ---- reset mid-vector ----
        out_ready = 1'b0;
        beat(16'h4400, 1'b0, 1'b1);
        beat(16'h5000, 1'b0, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_data", out_data, 16'h0);
        chk("midrst_out_idx", out_idx, 8'h0);
        vec_q.delete();
        vec_q.push_back(16'h3800);
        run_vector(1'b0, 16'h3800, 0, 1'b0, 0);
        $display("reset-recovery: data=%04h idx=%0d", out_data, out_idx);

        // ---- randomized against the reference model ----
        for (int r = 0; r < 40; r++) begin
            vec_q.delete();
            len = (r == 20) ? 270 : $urandom_range(1, 12);
            for (int k = 0; k < len; k++) vec_q.push_back(rand_elem());
            m = 1'($urandom);
            model(m, ed, ei, en);
            run_vector(m, ed, ei, en, $urandom_range(0, 3));
            $display("random %0d: mode=%0d len=%0d -> exp data=%04h idx=%0d nan=%0d",
                     r, m, len, ed, ei, en);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
